// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg
// Shared types and constants for the multicycle RV32I control FSM.
//   state_e        : controller state encoding
//   instr_class_e  : coarse instruction class produced by pc_ctrl_decode
//   OPC_*          : RV32I major opcodes (instr[6:0])
//   INSTR_*        : exact encodings of the supported SYSTEM instructions
//   CAUSE_*        : mcause values raised by the controller
package pc_ctrl_pkg;

   typedef enum logic [3:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      BRANCH,
      JUMP,
      SYSTEM,
      TRAP
   } state_e;

   typedef enum logic [2:0] {
      CLS_NONE,
      CLS_ALU,
      CLS_MEM,
      CLS_BRANCH,
      CLS_JUMP,
      CLS_SYSTEM,
      CLS_FENCE
   } instr_class_e;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

   localparam logic [31:0] CAUSE_FETCH_FAULT = 32'd1;
   localparam logic [31:0] CAUSE_ILLEGAL     = 32'd2;
   localparam logic [31:0] CAUSE_BREAKPOINT  = 32'd3;
   localparam logic [31:0] CAUSE_LOAD_FAULT  = 32'd5;
   localparam logic [31:0] CAUSE_STORE_FAULT = 32'd7;
   localparam logic [31:0] CAUSE_ECALL_M     = 32'd11;
   localparam logic [31:0] CAUSE_IRQ_EXT     = 32'h8000_000B;

endpackage

// File: rtl/pc_ctrl_decode.sv
// pc_ctrl_decode
// Combinational classifier for the instruction register contents.
// Ports:
//   instr_i   : instruction register contents
//   cls_o     : instruction class (CLS_NONE when illegal)
//   store_o   : memory access is a store (otherwise a load)
//   jalr_o    : jump is JALR (otherwise JAL)
//   ecall_o, ebreak_o, mret_o : supported SYSTEM instructions
//   illegal_o : opcode or SYSTEM encoding not supported
module pc_ctrl_decode
   import pc_ctrl_pkg::*;
(
   input  logic [31:0]  instr_i,
   output instr_class_e cls_o,
   output logic         store_o,
   output logic         jalr_o,
   output logic         ecall_o,
   output logic         ebreak_o,
   output logic         mret_o,
   output logic         illegal_o
);

   logic [6:0] opcode;

   assign opcode   = instr_i[6:0];
   // SYSTEM instructions are matched on the full word; CSR accesses are not supported
   assign ecall_o  = (instr_i == INSTR_ECALL);
   assign ebreak_o = (instr_i == INSTR_EBREAK);
   assign mret_o   = (instr_i == INSTR_MRET);
   assign store_o  = (opcode == OPC_STORE);
   assign jalr_o   = (opcode == OPC_JALR);

   // Map the major opcode onto the state the controller visits after DECODE
   always_comb begin
      cls_o     = CLS_NONE;
      illegal_o = 1'b0;
      case (opcode)
         OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: cls_o = CLS_ALU;
         OPC_LOAD, OPC_STORE:                    cls_o = CLS_MEM;
         OPC_BRANCH:                             cls_o = CLS_BRANCH;
         OPC_JAL, OPC_JALR:                      cls_o = CLS_JUMP;
         OPC_MISC_MEM:                           cls_o = CLS_FENCE;
         OPC_SYSTEM: begin
            if (ecall_o || ebreak_o || mret_o) begin
               cls_o = CLS_SYSTEM;
            end else begin
               illegal_o = 1'b1;
            end
         end
         default:                                illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl
// Multicycle control FSM sequencing PC, instruction register, register-file
// write and data-memory access for one RV32I instruction at a time. Outputs are
// combinational from the current state and inputs.
// Parameter TIMEOUT_CYCLES: memory wait limit before an access-fault trap (0 = never).
// Optional feature macro PC_CTRL_IRQ_EN: take irq_i on entry to FETCH.
// Ports:
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   instr_i                 : instruction register contents
//   branch_taken_i          : branch comparison result
//   irq_i                   : external interrupt request (level)
//   imem_req_o/imem_rvalid_i: instruction fetch handshake
//   dmem_req_o/dmem_we_o/dmem_rvalid_i : data access handshake
//   ir_en_o, rf_we_o        : instruction register latch, register-file write
//   pc_en_o, pc_sel_*_o, pc_add_imm_o : PC update control
//   mepc_we_o, mepc_cur_o, mcause_we_o, mcause_o : trap CSR updates
module pc_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] instr_i,
   input  logic        branch_taken_i,
   input  logic        irq_i,
   output logic        imem_req_o,
   input  logic        imem_rvalid_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   input  logic        dmem_rvalid_i,
   output logic        ir_en_o,
   output logic        rf_we_o,
   output logic        pc_en_o,
   output logic        pc_sel_alu_o,
   output logic        pc_sel_pc_base_o,
   output logic        pc_add_imm_o,
   output logic        pc_sel_mtvec_o,
   output logic        pc_sel_mepc_o,
   output logic        mepc_we_o,
   output logic        mepc_cur_o,
   output logic        mcause_we_o,
   output logic [31:0] mcause_o
);

   state_e       state_q, state_d;
   logic [31:0]  cnt_q, cnt_d;
   logic [31:0]  cause_q, cause_d;
   logic         irqTrap_q, irqTrap_d;
   logic         goFetch;
   logic         timeoutHit;
   instr_class_e cls;
   logic         isStore, isJalr, isEcall, isEbreak, isMret, isIllegal;

   pc_ctrl_decode u_decode (
      .instr_i   (instr_i),
      .cls_o     (cls),
      .store_o   (isStore),
      .jalr_o    (isJalr),
      .ecall_o   (isEcall),
      .ebreak_o  (isEbreak),
      .mret_o    (isMret),
      .illegal_o (isIllegal)
   );

`ifndef PC_CTRL_IRQ_EN
   logic unusedIrq;
   assign unusedIrq = irq_i;
`endif

   // The limit is hit on the last allowed waiting cycle, so a response arriving
   // in that same cycle is still accepted.
   assign timeoutHit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1);

   // Next-state and Mealy output logic
   always_comb begin
      state_d          = state_q;
      cause_d          = cause_q;
      irqTrap_d        = irqTrap_q;
      goFetch          = 1'b0;
      imem_req_o       = 1'b0;
      dmem_req_o       = 1'b0;
      dmem_we_o        = 1'b0;
      ir_en_o          = 1'b0;
      rf_we_o          = 1'b0;
      pc_en_o          = 1'b0;
      pc_sel_alu_o     = 1'b0;
      pc_sel_pc_base_o = 1'b0;
      pc_add_imm_o     = 1'b0;
      pc_sel_mtvec_o   = 1'b0;
      pc_sel_mepc_o    = 1'b0;
      mepc_we_o        = 1'b0;
      mepc_cur_o       = 1'b0;
      mcause_we_o      = 1'b0;
      mcause_o         = 32'd0;
      case (state_q)
         IDLE: goFetch = 1'b1;
         FETCH: begin
            imem_req_o = 1'b1;
            if (imem_rvalid_i) begin
               ir_en_o = 1'b1;
               state_d = DECODE;
            end else if (timeoutHit) begin
               state_d   = TRAP;
               cause_d   = CAUSE_FETCH_FAULT;
               irqTrap_d = 1'b0;
            end
         end
         DECODE: begin
            pc_en_o = 1'b1;
            if (isIllegal) begin
               state_d   = TRAP;
               cause_d   = CAUSE_ILLEGAL;
               irqTrap_d = 1'b0;
            end else begin
               case (cls)
                  CLS_ALU:    state_d = EXEC;
                  CLS_MEM:    state_d = MEM;
                  CLS_BRANCH: state_d = BRANCH;
                  CLS_JUMP:   state_d = JUMP;
                  CLS_SYSTEM: state_d = SYSTEM;
                  default:    goFetch = 1'b1;
               endcase
            end
         end
         EXEC: begin
            rf_we_o = 1'b1;
            goFetch = 1'b1;
         end
         MEM: begin
            dmem_req_o = 1'b1;
            dmem_we_o  = isStore;
            if (dmem_rvalid_i) begin
               if (isStore) begin
                  goFetch = 1'b1;
               end else begin
                  state_d = WB;
               end
            end else if (timeoutHit) begin
               state_d   = TRAP;
               cause_d   = isStore ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
               irqTrap_d = 1'b0;
            end
         end
         WB: begin
            rf_we_o = 1'b1;
            goFetch = 1'b1;
         end
         BRANCH: begin
            // PC already holds PC+4, so the base select compensates by -4
            if (branch_taken_i) begin
               pc_en_o          = 1'b1;
               pc_add_imm_o     = 1'b1;
               pc_sel_pc_base_o = 1'b1;
            end
            goFetch = 1'b1;
         end
         JUMP: begin
            rf_we_o = 1'b1;
            pc_en_o = 1'b1;
            if (isJalr) begin
               pc_sel_alu_o = 1'b1;
            end else begin
               pc_add_imm_o     = 1'b1;
               pc_sel_pc_base_o = 1'b1;
            end
            goFetch = 1'b1;
         end
         SYSTEM: begin
            if (isMret) begin
               pc_en_o       = 1'b1;
               pc_sel_mepc_o = 1'b1;
               goFetch       = 1'b1;
            end else begin
               state_d   = TRAP;
               cause_d   = isEbreak ? CAUSE_BREAKPOINT : CAUSE_ECALL_M;
               irqTrap_d = 1'b0;
            end
         end
         TRAP: begin
            mepc_we_o      = 1'b1;
            mcause_we_o    = 1'b1;
            pc_en_o        = 1'b1;
            pc_sel_mtvec_o = 1'b1;
            mepc_cur_o     = irqTrap_q;
            mcause_o       = cause_q;
            goFetch        = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // Every path into FETCH funnels through here so the interrupt check sits
      // in one place. The transition out of TRAP is exempt so the first handler
      // instruction is always fetched even while the request line stays high.
      if (goFetch) begin
`ifdef PC_CTRL_IRQ_EN
         if (irq_i && (state_q != TRAP)) begin
            state_d   = TRAP;
            cause_d   = CAUSE_IRQ_EXT;
            irqTrap_d = 1'b1;
         end else begin
            state_d = FETCH;
         end
`else
         state_d = FETCH;
`endif
      end

      // Only FETCH and MEM ever remain in place, so any state change clears the count
      cnt_d = (state_d == state_q) ? cnt_q + 32'd1 : 32'd0;
   end

   // State, wait counter and pending trap information
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= 32'd0;
         cause_q   <= 32'd0;
         irqTrap_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cause_q   <= cause_d;
         irqTrap_q <= irqTrap_d;
      end
   end

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl
// Directed bench for pc_ctrl. The main instance uses TIMEOUT_CYCLES=4; a second
// instance with TIMEOUT_CYCLES=0 shows that an unacknowledged store waits forever.
// A small PC/mepc model driven by the controller outputs tracks the program flow.
// Honors PC_CTRL_IRQ_EN for the interrupt step.
module tb_pc_ctrl;

   localparam logic [13:0] IMEM   = 14'h2000;
   localparam logic [13:0] DREQ   = 14'h1000;
   localparam logic [13:0] DWE    = 14'h0800;
   localparam logic [13:0] IREN   = 14'h0400;
   localparam logic [13:0] RFWE   = 14'h0200;
   localparam logic [13:0] PCEN   = 14'h0100;
   localparam logic [13:0] SALU   = 14'h0080;
   localparam logic [13:0] SBASE  = 14'h0040;
   localparam logic [13:0] AIMM   = 14'h0020;
   localparam logic [13:0] SMTV   = 14'h0010;
   localparam logic [13:0] SMEPC  = 14'h0008;
   localparam logic [13:0] MEPCWE = 14'h0004;
   localparam logic [13:0] MCUR   = 14'h0002;
   localparam logic [13:0] MCWE   = 14'h0001;
   localparam logic [13:0] TRAPC  = MEPCWE | MCWE | PCEN | SMTV;

   localparam logic [31:0] I_ADDI   = 32'h0010_0093;
   localparam logic [31:0] I_BEQ    = 32'h0000_0863;
   localparam logic [31:0] I_LW     = 32'h0000_2083;
   localparam logic [31:0] I_SW     = 32'h0010_2023;
   localparam logic [31:0] I_ILL    = 32'hFFFF_FFFF;
   localparam logic [31:0] I_MRET   = 32'h3020_0073;
   localparam logic [31:0] I_ECALL  = 32'h0000_0073;
   localparam logic [31:0] I_EBREAK = 32'h0010_0073;
   localparam logic [31:0] I_JAL    = 32'h0100_00EF;
   localparam logic [31:0] I_JALR   = 32'h0000_80E7;
   localparam logic [31:0] I_FENCE  = 32'h0000_000F;

   localparam logic [31:0] MTVEC      = 32'h0000_0100;
   localparam logic [31:0] ALU_TARGET = 32'h0000_0200;
   localparam logic [31:0] IMM        = 32'd16;

   logic        clock = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        imemRvalid, dmemRvalid, branchTaken, irq;
   logic        imemReq, dmemReq, dmemWe, irEn, rfWe, pcEn, selAlu, selBase, addImm;
   logic        selMtvec, selMepc, mepcWe, mepcCur, mcauseWe;
   logic [31:0] mcause;
   logic [13:0] ctl;

   logic        zRst_n;
   logic [31:0] zInstr;
   logic        zIv, zDv;
   logic        zImem, zDreq, zDwe, zIren, zRfwe, zPcen, zSalu, zSbase, zAimm;
   logic        zSmtv, zSmepc, zMepcWe, zMcur, zMcwe;
   logic [31:0] zCause;
   logic [3:0]  zCtl;

   logic [31:0] pcModel, mepcModel;
   int          assertCount = 0;
   int          failCount = 0;

   always #5 clock = ~clock;

   pc_ctrl #(.TIMEOUT_CYCLES(4)) dut (
      .clk_i(clock), .rst_ni(rst_n), .instr_i(instr), .branch_taken_i(branchTaken),
      .irq_i(irq), .imem_req_o(imemReq), .imem_rvalid_i(imemRvalid),
      .dmem_req_o(dmemReq), .dmem_we_o(dmemWe), .dmem_rvalid_i(dmemRvalid),
      .ir_en_o(irEn), .rf_we_o(rfWe), .pc_en_o(pcEn), .pc_sel_alu_o(selAlu),
      .pc_sel_pc_base_o(selBase), .pc_add_imm_o(addImm), .pc_sel_mtvec_o(selMtvec),
      .pc_sel_mepc_o(selMepc), .mepc_we_o(mepcWe), .mepc_cur_o(mepcCur),
      .mcause_we_o(mcauseWe), .mcause_o(mcause)
   );

   pc_ctrl #(.TIMEOUT_CYCLES(0)) dutNoTimeout (
      .clk_i(clock), .rst_ni(zRst_n), .instr_i(zInstr), .branch_taken_i(1'b0),
      .irq_i(1'b0), .imem_req_o(zImem), .imem_rvalid_i(zIv),
      .dmem_req_o(zDreq), .dmem_we_o(zDwe), .dmem_rvalid_i(zDv),
      .ir_en_o(zIren), .rf_we_o(zRfwe), .pc_en_o(zPcen), .pc_sel_alu_o(zSalu),
      .pc_sel_pc_base_o(zSbase), .pc_add_imm_o(zAimm), .pc_sel_mtvec_o(zSmtv),
      .pc_sel_mepc_o(zSmepc), .mepc_we_o(zMepcWe), .mepc_cur_o(zMcur),
      .mcause_we_o(zMcwe), .mcause_o(zCause)
   );

   assign ctl  = {imemReq, dmemReq, dmemWe, irEn, rfWe, pcEn, selAlu, selBase,
                  addImm, selMtvec, selMepc, mepcWe, mepcCur, mcauseWe};
   assign zCtl = {zImem, zDreq, zDwe, zMcwe};

   // Architectural PC and mepc as the datapath would update them
   always @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         pcModel   <= 32'h8000_0000;
         mepcModel <= 32'd0;
      end else begin
         if (mepcWe) mepcModel <= mepcCur ? pcModel : pcModel - 32'd4;
         if (pcEn) begin
            if (selMtvec)                pcModel <= MTVEC;
            else if (selMepc)            pcModel <= mepcModel;
            else if (selAlu)             pcModel <= ALU_TARGET;
            else if (selBase && addImm)  pcModel <= pcModel - 32'd4 + IMM;
            else                         pcModel <= pcModel + 32'd4;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One clock cycle on the main instance: drive, check at negedge, advance past posedge
   task automatic applyStimulus(input logic [31:0] ins, input logic iv, input logic dv,
                                input logic bt, input logic ir, input logic [13:0] expCtl,
                                input logic [31:0] expCause, input string tag);
      instr       = ins;
      imemRvalid  = iv;
      dmemRvalid  = dv;
      branchTaken = bt;
      irq         = ir;
      @(negedge clock);
      checkOutput({tag, " ctl"}, {18'd0, ctl}, {18'd0, expCtl});
      checkOutput({tag, " cause"}, mcause, expCause);
      @(posedge clock);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; zRst_n = 1'b0;
      instr = 32'd0; imemRvalid = 1'b0; dmemRvalid = 1'b0; branchTaken = 1'b0; irq = 1'b0;
      zInstr = 32'd0; zIv = 1'b0; zDv = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkOutput("reset ctl", {18'd0, ctl}, 32'd0);
      checkOutput("reset pc", pcModel, 32'h8000_0000);
      @(posedge clock);
      #1;
      rst_n = 1'b1;

      // ADDI with zero-wait fetch
      applyStimulus(I_ADDI, 0, 0, 0, 0, 14'd0, 0, "idle");
      applyStimulus(I_ADDI, 1, 0, 0, 0, IMEM | IREN, 0, "addi fetch");
      applyStimulus(I_ADDI, 0, 0, 0, 0, PCEN, 0, "addi decode");
      applyStimulus(I_ADDI, 0, 0, 0, 0, RFWE, 0, "addi exec");
      checkOutput("pc after addi", pcModel, 32'h8000_0004);

      // BEQ +16 taken, with one fetch wait cycle
      applyStimulus(I_BEQ, 0, 0, 0, 0, IMEM, 0, "beq fetch wait");
      applyStimulus(I_BEQ, 1, 0, 0, 0, IMEM | IREN, 0, "beq fetch");
      applyStimulus(I_BEQ, 0, 0, 0, 0, PCEN, 0, "beq decode");
      applyStimulus(I_BEQ, 0, 0, 1, 0, PCEN | SBASE | AIMM, 0, "beq taken");
      checkOutput("pc after taken", pcModel, 32'h8000_0014);

      // BEQ not taken
      applyStimulus(I_BEQ, 1, 0, 0, 0, IMEM | IREN, 0, "beq2 fetch");
      applyStimulus(I_BEQ, 0, 0, 0, 0, PCEN, 0, "beq2 decode");
      applyStimulus(I_BEQ, 0, 0, 0, 0, 14'd0, 0, "beq not taken");
      checkOutput("pc after not taken", pcModel, 32'h8000_0018);

      // LW, stray dmem response during fetch, response on the 4th MEM cycle (limit cycle)
      applyStimulus(I_LW, 0, 1, 0, 0, IMEM, 0, "lw stray dmem");
      applyStimulus(I_LW, 1, 0, 0, 0, IMEM | IREN, 0, "lw fetch");
      applyStimulus(I_LW, 0, 0, 0, 0, PCEN, 0, "lw decode");
      for (int i = 0; i < 3; i++) applyStimulus(I_LW, 0, 0, 0, 0, DREQ, 0, "lw wait");
      applyStimulus(I_LW, 0, 1, 0, 0, DREQ, 0, "lw response");
      applyStimulus(I_LW, 0, 0, 0, 0, RFWE, 0, "lw wb");

      // Illegal instruction, then mret back to it
      applyStimulus(I_ILL, 1, 0, 0, 0, IMEM | IREN, 0, "ill fetch");
      applyStimulus(I_ILL, 0, 0, 0, 0, PCEN, 0, "ill decode");
      applyStimulus(I_ILL, 0, 0, 0, 0, TRAPC, 32'd2, "ill trap");
      checkOutput("pc after ill", pcModel, MTVEC);
      checkOutput("mepc after ill", mepcModel, 32'h8000_001C);
      applyStimulus(I_MRET, 1, 0, 0, 0, IMEM | IREN, 0, "mret fetch");
      applyStimulus(I_MRET, 0, 0, 0, 0, PCEN, 0, "mret decode");
      applyStimulus(I_MRET, 0, 0, 0, 0, PCEN | SMEPC, 0, "mret system");
      checkOutput("pc after mret", pcModel, 32'h8000_001C);

      // ecall and ebreak
      applyStimulus(I_ECALL, 1, 0, 0, 0, IMEM | IREN, 0, "ecall fetch");
      applyStimulus(I_ECALL, 0, 0, 0, 0, PCEN, 0, "ecall decode");
      applyStimulus(I_ECALL, 0, 0, 0, 0, 14'd0, 0, "ecall system");
      applyStimulus(I_ECALL, 0, 0, 0, 0, TRAPC, 32'd11, "ecall trap");
      applyStimulus(I_EBREAK, 1, 0, 0, 0, IMEM | IREN, 0, "ebreak fetch");
      applyStimulus(I_EBREAK, 0, 0, 0, 0, PCEN, 0, "ebreak decode");
      applyStimulus(I_EBREAK, 0, 0, 0, 0, 14'd0, 0, "ebreak system");
      applyStimulus(I_EBREAK, 0, 0, 0, 0, TRAPC, 32'd3, "ebreak trap");

      // JAL +16 then JALR
      applyStimulus(I_JAL, 1, 0, 0, 0, IMEM | IREN, 0, "jal fetch");
      applyStimulus(I_JAL, 0, 0, 0, 0, PCEN, 0, "jal decode");
      applyStimulus(I_JAL, 0, 0, 0, 0, RFWE | PCEN | SBASE | AIMM, 0, "jal jump");
      checkOutput("pc after jal", pcModel, 32'h0000_0110);
      applyStimulus(I_JALR, 1, 0, 0, 0, IMEM | IREN, 0, "jalr fetch");
      applyStimulus(I_JALR, 0, 0, 0, 0, PCEN, 0, "jalr decode");
      applyStimulus(I_JALR, 0, 0, 0, 0, RFWE | PCEN | SALU, 0, "jalr jump");
      checkOutput("pc after jalr", pcModel, ALU_TARGET);

      // Store never acknowledged: trap after 4 waiting cycles
      applyStimulus(I_SW, 1, 0, 0, 0, IMEM | IREN, 0, "sw fetch");
      applyStimulus(I_SW, 0, 0, 0, 0, PCEN, 0, "sw decode");
      for (int i = 0; i < 4; i++) applyStimulus(I_SW, 0, 0, 0, 0, DREQ | DWE, 0, "sw wait");
      applyStimulus(I_SW, 0, 0, 0, 0, TRAPC, 32'd7, "sw timeout trap");
      checkOutput("mepc after sw timeout", mepcModel, ALU_TARGET);

      // Fetch never answered: trap with cause 1
      for (int i = 0; i < 4; i++) applyStimulus(I_SW, 0, 0, 0, 0, IMEM, 0, "fetch wait");
      applyStimulus(I_SW, 0, 0, 0, 0, TRAPC, 32'd1, "fetch timeout trap");

      // FENCE goes straight back to FETCH
      applyStimulus(I_FENCE, 1, 0, 0, 0, IMEM | IREN, 0, "fence fetch");
      applyStimulus(I_FENCE, 0, 0, 0, 0, PCEN, 0, "fence decode");

      // Interrupt pending when the next FETCH would be entered
      applyStimulus(I_ADDI, 1, 0, 0, 0, IMEM | IREN, 0, "irq addi fetch");
      applyStimulus(I_ADDI, 0, 0, 0, 0, PCEN, 0, "irq addi decode");
      applyStimulus(I_ADDI, 0, 0, 0, 1, RFWE, 0, "irq addi exec");
`ifdef PC_CTRL_IRQ_EN
      applyStimulus(I_ADDI, 0, 0, 0, 1, TRAPC | MCUR, 32'h8000_000B, "irq trap");
      checkOutput("mepc after irq", mepcModel, 32'h0000_0108);
      applyStimulus(I_ADDI, 0, 0, 0, 0, IMEM, 0, "fetch after irq");
`else
      applyStimulus(I_ADDI, 0, 0, 0, 1, IMEM, 0, "irq ignored fetch");
`endif

      // Asynchronous reset in the middle of a fetch drops the request at once
      #2;
      checkOutput("fetch before reset", {18'd0, ctl}, {18'd0, IMEM});
      rst_n = 1'b0;
      #1;
      checkOutput("reset drops request", {18'd0, ctl}, 32'd0);

      // TIMEOUT_CYCLES=0 instance: an unacknowledged store waits indefinitely
      @(posedge clock);
      #1;
      zRst_n = 1'b1;
      @(negedge clock);
      checkOutput("nt idle", {28'd0, zCtl}, 32'd0);
      @(posedge clock);
      #1;
      zInstr = I_SW; zIv = 1'b1;
      @(negedge clock);
      checkOutput("nt fetch", {28'd0, zCtl}, 32'h8);
      @(posedge clock);
      #1;
      zIv = 1'b0;
      @(posedge clock);
      #1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         checkOutput("nt store wait", {28'd0, zCtl}, 32'h6);
         @(posedge clock);
         #1;
      end
      zDv = 1'b1;
      @(posedge clock);
      #1;
      zDv = 1'b0;
      @(negedge clock);
      checkOutput("nt fetch after ack", {28'd0, zCtl}, 32'h8);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
